gb_audio_i2s_tx: RTL
====================

# gb_audio_i2s_tx

Stereo mixer and I2S transmitter on the consumer side of the four sound channels (square1, square2, wave, noise). Once per audio frame it latches the 4-bit outputs of the four channels and applies NR51 panning and NR50 master volume. It then scales each stereo sum to 24 bits and shifts it out MSB-first to the board audio codec DAC. It also generates the codec's bit clock and left/right clock from system_clock.

## Interface
Parameters:
- CLK_DIV, default 1: system_clock cycles per half BCLK period; must be ≥1. BCLK = system_clock/(2·CLK_DIV). With a 4.194304 MHz system_clock and the default, the sample rate is 32768 Hz.

Ports:
- system_clock  in  1  sole clock; all state on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- ch1_sample, ch2_sample, ch3_sample, ch4_sample  in  4 each  unsigned channel outputs, 0..15.
- NR50  in  8  [6:4] left volume, [2:0] right volume; bits 7 and 3 are ignored.
- NR51  in  8  [7:4] channel 4..1 to left; [3:0] channel 4..1 to right.
- NR52  in  8  bit 7 is the master sound enable; other bits are ignored.
- aud_bclk  out  1  codec bit clock.
- aud_daclrck  out  1  0 = left slot, 1 = right slot.
- aud_dacdat  out  1  serial data.
- sample_strobe  out  1  one-cycle pulse when a new stereo pair is latched.

## Operation
- Counters:
  - div_cnt runs 0..CLK_DIV-1. At CLK_DIV-1 it wraps and aud_bclk toggles.
  - A toggle 1→0 is a "fall event". bit_cnt (6 bits, 0..63) increments with wrap on each fall event.
- Latch, at the fall event where bit_cnt wraps 63→0:
  - mixL = (sum of ch_i where NR51[4+i-1]=1) × (NR50[6:4]+1). The sum is 0..60 and mixL is 0..480, 9 bits, unsigned, no saturation needed.
  - mixR is computed the same way from NR51[i-1] and NR50[2:0].
  - If NR52[7]=0, mixL = mixR = 0.
  - Each word is formed as {1'b0, mix[8:0], 14'b0}, 24 bits with a maximum of 0x780000.
  - Both words go to holding registers and sample_strobe pulses in that same cycle.
  - All inputs are sampled only at this instant. Changes mid-frame take effect next frame.
- I2S framing:
  - On every fall event, aud_daclrck ← (new bit_cnt ≥ 32).
  - Slot position k = new bit_cnt mod 32. The left word drives slot 0..31 and the right word drives 32..63.
  - aud_dacdat ← word[24-k] for k = 1..24, else 0. So the MSB appears one BCLK after the LRCK edge, per standard I2S.
  - Data and LRCK change only at fall events, so they are stable across each aud_bclk rising edge.
- No backpressure. The frame runs continuously after reset.

## Timing
- Reset values:
  - aud_bclk = 0, aud_daclrck = 0, aud_dacdat = 0, sample_strobe = 0.
  - div_cnt = 0, bit_cnt = 63, holding words = 0.
- After reset deasserts:
  - The first aud_bclk rise occurs CLK_DIV cycles later.
  - The first fall event occurs 2·CLK_DIV cycles later. It wraps bit_cnt to 0, latches, and pulses sample_strobe.
- Frame period is 128·CLK_DIV cycles. sample_strobe period is exactly the same.
- Latency: a value present on the inputs at the latch cycle has its MSB on aud_dacdat 2·CLK_DIV cycles later (left) and 66·CLK_DIV cycles later (right).
- Reset asserted mid-frame: all outputs go to their reset values immediately (asynchronously), including aud_bclk if it was high. The frame restarts from the reset sequence and the partial word is discarded.
- CLK_DIV = 1: aud_bclk toggles every cycle and all of the above holds unchanged.

## Test plan
- Reset / startup:
  - Hold reset low, then release with CLK_DIV=1.
  - Required: all outputs are 0 during reset. aud_bclk rises at cycle 1 and falls at cycle 2. sample_strobe is high only at cycle 2, then every 128 cycles.
- Single channel, both sides:
  - Stimulus: ch1=15, others 0, NR51=0x11, NR50=0x77, NR52=0x80.
  - Required: the bench deserializer reads left = right = 0x1E0000 (120<<14).
  - Bit check: left slot k=1 is 0; k=4..7 are 1; k=25..31 are 0.
- Full scale with panning:
  - All channels = 15, NR50=0x77.
  - NR51=0xFF gives left = right = 0x780000.
  - NR51=0xF0 gives left = 0x780000, right = 0x000000.
  - NR50=0x70 with NR51=0xFF gives right = 0x0F0000.
- Master disable:
  - NR52=0x00 with the full-scale stimulus.
  - Required: both words are 0 and aud_dacdat stays 0 for the whole frame. The clocks keep running.
- Mid-frame input change:
  - At bit_cnt=10, change ch1 from 15 to 0.
  - Required: the current frame's left and right words are unchanged. The change appears only in the frame after the next sample_strobe.
- Reset mid-frame:
  - Assert reset while aud_bclk=1 and aud_daclrck=1.
  - Required: aud_bclk, aud_daclrck and aud_dacdat drop to 0 with no clock edge.
  - After release, the startup sequence from the first scenario repeats exactly.

Source files
------------

// File: rtl/gb_audio_i2s_tx.sv
`default_nettype none
// ============================================================================
// gb_audio_i2s_tx
// Mixes four sound channels with NR51/NR50 into 24-bit words and sends them as I2S.
// Revision: 1.0
// ============================================================================
module gb_audio_i2s_tx #(
  parameter int CLK_DIV = 1
) (
  input  logic       system_clock,
  input  logic       reset,
  input  logic [3:0] ch1_sample,
  input  logic [3:0] ch2_sample,
  input  logic [3:0] ch3_sample,
  input  logic [3:0] ch4_sample,
  input  logic [7:0] NR50,
  input  logic [7:0] NR51,
  input  logic [7:0] NR52,
  output logic       aud_bclk,
  output logic       aud_daclrck,
  output logic       aud_dacdat,
  output logic       sample_strobe
);

  localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             bclk_q, bclk_d;
  logic [5:0]       bit_q, bit_d;
  logic             lrck_q, lrck_d;
  logic             dat_q, dat_d;
  logic             strobe_q, strobe_d;
  logic [23:0]      left_q, left_d;
  logic [23:0]      right_q, right_d;

  logic             div_last;
  logic             fall;
  logic             wrap;
  logic [5:0]       bit_nxt;
  logic [4:0]       slot;
  logic [23:0]      slot_word;
  logic [5:0]       sum_l, sum_r;
  logic [8:0]       mix_l, mix_r;
  logic [23:0]      word_l, word_r;
  logic             unused_bits;

  assign unused_bits = ^{NR50[7], NR50[3], NR52[6:0]};

  function automatic logic [5:0] pan_sum(input logic [3:0] en,
                                         input logic [3:0] c1,
                                         input logic [3:0] c2,
                                         input logic [3:0] c3,
                                         input logic [3:0] c4);
    logic [5:0] s;
    s = 6'd0;
    if (en[0]) s = s + {2'b00, c1};
    if (en[1]) s = s + {2'b00, c2};
    if (en[2]) s = s + {2'b00, c3};
    if (en[3]) s = s + {2'b00, c4};
    return s;
  endfunction

  // Mixer: panned sum times (volume+1); at most 60*8 = 480, fits 9 bits.
  always_comb begin
    sum_l  = pan_sum(NR51[7:4], ch1_sample, ch2_sample, ch3_sample, ch4_sample);
    sum_r  = pan_sum(NR51[3:0], ch1_sample, ch2_sample, ch3_sample, ch4_sample);
    mix_l  = {3'b000, sum_l} * {5'b00000, ({1'b0, NR50[6:4]} + 4'd1)};
    mix_r  = {3'b000, sum_r} * {5'b00000, ({1'b0, NR50[2:0]} + 4'd1)};
    if (!NR52[7]) begin
      mix_l = 9'd0;
      mix_r = 9'd0;
    end
    word_l = {1'b0, mix_l, 14'd0};
    word_r = {1'b0, mix_r, 14'd0};
  end

  always_comb begin
    div_last  = (div_q == DIV_LAST);
    fall      = div_last & bclk_q;
    bit_nxt   = bit_q + 6'd1;
    wrap      = fall & (bit_q == 6'd63);
    slot      = bit_nxt[4:0];
    slot_word = bit_nxt[5] ? right_q : left_q;

    div_d     = div_last ? '0 : div_q + DIV_W'(1);
    bclk_d    = div_last ? ~bclk_q : bclk_q;
    bit_d     = bit_q;
    lrck_d    = lrck_q;
    dat_d     = dat_q;
    strobe_d  = wrap;
    left_d    = wrap ? word_l : left_q;
    right_d   = wrap ? word_r : right_q;

    // Slot 0 is always 0, so the stale word seen at the latch fall is harmless.
    if (fall) begin
      bit_d  = bit_nxt;
      lrck_d = bit_nxt[5];
      if (slot >= 5'd1 && slot <= 5'd24) begin
        dat_d = slot_word[5'd24 - slot];
      end else begin
        dat_d = 1'b0;
      end
    end
  end

  always_ff @(posedge system_clock or negedge reset) begin
    if (!reset) begin
      div_q    <= '0;
      bclk_q   <= 1'b0;
      bit_q    <= 6'd63;
      lrck_q   <= 1'b0;
      dat_q    <= 1'b0;
      strobe_q <= 1'b0;
      left_q   <= 24'd0;
      right_q  <= 24'd0;
    end else begin
      div_q    <= div_d;
      bclk_q   <= bclk_d;
      bit_q    <= bit_d;
      lrck_q   <= lrck_d;
      dat_q    <= dat_d;
      strobe_q <= strobe_d;
      left_q   <= left_d;
      right_q  <= right_d;
    end
  end

  assign aud_bclk      = bclk_q;
  assign aud_daclrck   = lrck_q;
  assign aud_dacdat    = dat_q;
  assign sample_strobe = strobe_q;

endmodule
`default_nettype wire
